twi_mirror_target: RTL

//   Clocked I2C target on the mirror side of the TWI proxy. It samples mirrorScl/mirrorSdaIn and

---
 rtl/twi_pkg.sv | 28 ++
 rtl/twi_line_sync.sv | 64 ++++++
 rtl/twi_mirror_target.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI mirror-side target.
// Defining TWI_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL and SDA
// after the input synchronisers.
package twi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } twiState_t;

  localparam logic       ACK               = 1'b0;
  localparam logic       NACK              = 1'b1;
  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

  // General call is never answered, even if the target address were set to it.
  function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] target);
    return (rx_addr == target) && (rx_addr != GENERAL_CALL_ADDR);
  endfunction

endpackage

// File: rtl/twi_line_sync.sv
// Synchroniser and edge detector for one TWI line (SCL or SDA).
// With TWI_GLITCH_FILTER_EN defined, a 3-sample majority filter follows the
// synchroniser (2 extra clocks of latency, single-clock pulses rejected).
module twi_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic line_in,
  output logic line_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stage_out;
  logic                   level;
  logic                   prev_q;

  // Synchroniser chain; resets to the idle-high bus level so release makes no edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
  end

  assign stage_out = sync_q[SYNC_STAGES-1];

`ifdef TWI_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       filt_d;

  // Majority vote over the current and two previous synchronised samples.
  always_comb begin
    filt_d = (stage_out & hist_q[0]) | (stage_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  // Sample history and registered filter output.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], stage_out};
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = stage_out;
`endif

  // Previous level, used to turn level changes into single-clock pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_q <= 1'b1;
    else         prev_q <= level;
  end

  assign line_out = level;
  assign rise     = level & ~prev_q;
  assign fall     = ~level & prev_q;

endmodule

// File: rtl/twi_mirror_target.sv
// Clocked I2C target on the mirror side of the TWI proxy: answers one 7-bit
// address, pulls SDA low through mirrorSdaLow, and exposes an 8-bit pointer
// register interface. Optional input filter: TWI_GLITCH_FILTER_EN.
module twi_mirror_target
  import twi_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       mirrorScl,
  input  logic       mirrorSdaIn,
  output logic       mirrorSdaLow,
  output logic       wrValid,
  output logic [7:0] wrAddr,
  output logic [7:0] wrData,
  output logic       rdReq,
  output logic [7:0] rdAddr,
  input  logic [7:0] rdData,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  twi_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .resetN(resetN), .line_in(mirrorScl),
    .line_out(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  twi_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .resetN(resetN), .line_in(mirrorSdaIn),
    .line_out(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  twiState_t  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       ack_on_q, ack_on_d;
  logic       sda_low_q, sda_low_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_req_q, rd_req_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_lvl};

  // Next-state logic: START/STOP override everything, otherwise step the byte protocol.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    ack_on_d   = ack_on_q;
    sda_low_d  = sda_low_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;

    if (rd_req_q) tx_d = rdData;

    if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      ack_on_d  = 1'b0;
      sda_low_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      ack_on_d  = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_low_d = 1'b0;
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (addr_match(rx_byte[7:1], TARGET_ADDR)) begin
              state_d = ADDR_ACK;
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
              if (rx_byte[0]) begin
                rd_req_d  = 1'b1;
                rd_addr_d = ptr_q;
              end
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        PTR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = rx_byte;
            state_d = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = rx_byte;
            ptr_d      = ptr_q + 8'd1;
            state_d    = WDATA_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ack_on_q) begin
            sda_low_d = ~ACK;
            ack_on_d  = 1'b1;
          end else begin
            ack_on_d  = 1'b0;
            bit_cnt_d = 3'd0;
            sda_low_d = 1'b0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RDATA;
              sda_low_d = ~tx_q[7];
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_fall) sda_low_d = ~tx_q[3'd7 - bit_cnt_q];
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RACK;
          end
        end
        RACK: begin
          if (scl_fall) sda_low_d = 1'b0;
          if (scl_rise) begin
            if (sda_lvl == NACK) begin
              state_d = IGNORE;
            end else begin
              ptr_d     = ptr_q + 8'd1;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q + 8'd1;
              bit_cnt_d = 3'd0;
              state_d   = RDATA;
            end
          end
        end
        IGNORE:  sda_low_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; async reset releases SDA immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      ack_on_q   <= 1'b0;
      sda_low_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      ack_on_q   <= ack_on_d;
      sda_low_q  <= sda_low_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign mirrorSdaLow = sda_low_q;
  assign wrValid      = wr_valid_q;
  assign wrAddr       = wr_addr_q;
  assign wrData       = wr_data_q;
  assign rdReq        = rd_req_q;
  assign rdAddr       = rd_addr_q;
  assign busy         = busy_q;

endmodule
